// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch, loader and instruction-RAM signal bundle for imem_port_arbiter
interface imem_port_arbiter_if #(
    parameter int RAM_SIZE_BIT = 10
);
    logic                    cpu_halt;
    logic                    f_req;
    logic [RAM_SIZE_BIT-1:0] f_addr;
    logic                    f_gnt;
    logic                    f_rvalid;
    logic [31:0]             f_rdata;
    logic                    l_req;
    logic                    l_we;
    logic [RAM_SIZE_BIT-1:0] l_addr;
    logic [31:0]             l_wdata;
    logic                    l_gnt;
    logic                    l_rvalid;
    logic [31:0]             l_rdata;
    logic                    l_err;
    logic                    mem_en;
    logic                    mem_we;
    logic [RAM_SIZE_BIT-1:0] mem_addr;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_halt, f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and RAM side
    modport master (
        output cpu_halt, f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/loader arbiter for a single-port instruction RAM (optional IMEM_ARB_WRITE_PROTECT_EN)
module imem_port_arbiter #(
    parameter int                      RAM_SIZE_BIT = 10,
    parameter int                      STARVE_LIMIT = 8,
    parameter logic [RAM_SIZE_BIT-1:0] PROTECT_TOP  = RAM_SIZE_BIT'(168)
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_port_arbiter_if.slave   bus
);
    localparam logic [1:0] TAG_NONE  = 2'd0;
    localparam logic [1:0] TAG_FETCH = 2'd1;
    localparam logic [1:0] TAG_LOAD  = 2'd2;
    localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);

    logic [7:0]              starve_q, starve_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [RAM_SIZE_BIT-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [1:0]              tag1_q, tag1_d, tag2_q;
    logic                    wr1_q, wr1_d, wr2_q;
    logic                    err1_q, err1_d, err2_q;
    logic                    l_gnt_w, f_gnt_w, l_prot;

    // Loader writes into the protected low region are acknowledged but never reach the RAM
`ifdef IMEM_ARB_WRITE_PROTECT_EN
    assign l_prot = !bus.cpu_halt && bus.l_we && (bus.l_addr < PROTECT_TOP);
`else
    assign l_prot = 1'b0;
`endif

    // Loader wins when halted, when starved, or when fetch is idle; fetch otherwise
    assign l_gnt_w = bus.l_req && (bus.cpu_halt || (starve_q == LIMIT) || !bus.f_req);
    assign f_gnt_w = bus.f_req && !l_gnt_w;
    assign bus.l_gnt = l_gnt_w;
    assign bus.f_gnt = f_gnt_w;

    // Next-state for the starve counter, the registered RAM command and the owner tag
    always_comb begin
        starve_d    = starve_q;
        mem_en_d    = f_gnt_w || (l_gnt_w && !l_prot);
        mem_we_d    = l_gnt_w && bus.l_we && !l_prot;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag1_d      = TAG_NONE;
        wr1_d       = l_gnt_w && bus.l_we;
        err1_d      = l_gnt_w && l_prot;
        if (!bus.l_req || l_gnt_w) begin
            starve_d = 8'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 8'd1;
        end
        if (l_gnt_w) begin
            mem_addr_d = bus.l_addr;
            tag1_d     = TAG_LOAD;
            if (bus.l_we) begin
                mem_wdata_d = bus.l_wdata;
            end
        end else if (f_gnt_w) begin
            mem_addr_d = bus.f_addr;
            tag1_d     = TAG_FETCH;
        end
    end

    // Register the RAM command and shift the owner tag two stages to line up with RAM read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q    <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            wr1_q       <= 1'b0;
            wr2_q       <= 1'b0;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            wr1_q       <= wr1_d;
            wr2_q       <= wr1_q;
            err1_q      <= err1_d;
            err2_q      <= err1_q;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Responses: RAM data steered to the owner; loader write acks carry zero data
    assign bus.f_rvalid = (tag2_q == TAG_FETCH);
    assign bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : 32'd0;
    assign bus.l_rvalid = (tag2_q == TAG_LOAD);
    assign bus.l_rdata  = (bus.l_rvalid && !wr2_q) ? bus.mem_rdata : 32'd0;
    assign bus.l_err    = bus.l_rvalid && err2_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] ram [0:1023];
    logic [31:0] fetch_exp [0:4];

    imem_port_arbiter_if #(.RAM_SIZE_BIT(10)) bus ();

    imem_port_arbiter #(
        .RAM_SIZE_BIT(10),
        .STARVE_LIMIT(8),
        .PROTECT_TOP (10'd168)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.f_req   = 1'b0;
        bus.l_req   = 1'b0;
        bus.l_we    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 1024; k++) ram[k] = 32'h1000_0000 | 32'(k);
        ram[0] = 32'h2417_0400;
        ram[1] = 32'h2408_0000;
        fetch_exp[0] = 32'h2417_0400;
        fetch_exp[1] = 32'h2408_0000;
        fetch_exp[2] = 32'h1000_0002;
        fetch_exp[3] = 32'h1000_0003;
        fetch_exp[4] = 32'h1000_0004;
        bus.mem_rdata = 32'd0;
        bus.cpu_halt  = 1'b0;
        bus.f_addr    = '0;
        bus.l_addr    = '0;
        bus.l_wdata   = 32'd0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state, no requests
        @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        chk("rst_l_err", 32'(bus.l_err), 32'd0);
        chk("rst_gnts", {30'd0, bus.f_gnt, bus.l_gnt}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
        end
        tick();

        // Fetch burst, addresses 0..4
        for (int i = 0; i < 9; i++) begin
            bus.f_req  = (i < 5);
            bus.f_addr = 10'(i);
            @(negedge clk);
            chk("burst_f_gnt", 32'(bus.f_gnt), 32'(i < 5));
            chk("burst_f_rvalid", 32'(bus.f_rvalid), 32'(i >= 2 && i < 7));
            if (i >= 2 && i < 7) chk("burst_f_rdata", bus.f_rdata, fetch_exp[i-2]);
            tick();
        end
        idle();

        // Halted loader write beats a concurrent fetch
        bus.cpu_halt = 1'b1;
        bus.f_req    = 1'b1;
        bus.f_addr   = 10'd7;
        bus.l_req    = 1'b1;
        bus.l_we     = 1'b1;
        bus.l_addr   = 10'd5;
        bus.l_wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("halt_l_gnt", 32'(bus.l_gnt), 32'd1);
        chk("halt_f_gnt", 32'(bus.f_gnt), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("halt_mem_en", 32'(bus.mem_en), 32'd1);
        chk("halt_mem_we", 32'(bus.mem_we), 32'd1);
        chk("halt_mem_addr", 32'(bus.mem_addr), 32'd5);
        chk("halt_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk("wr_ack_l_rvalid", 32'(bus.l_rvalid), 32'd1);
        chk("wr_ack_l_rdata", bus.l_rdata, 32'd0);
        chk("wr_ack_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        tick();

        // Loader read back of address 5
        bus.l_req  = 1'b1;
        bus.l_we   = 1'b0;
        bus.l_addr = 10'd5;
        @(negedge clk);
        chk("rd_l_gnt", 32'(bus.l_gnt), 32'd1);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("rd_l_rvalid", 32'(bus.l_rvalid), 32'd1);
        chk("rd_l_rdata", bus.l_rdata, 32'hDEAD_BEEF);
        chk("rd_f_rdata", bus.f_rdata, 32'd0);
        tick();
        bus.cpu_halt = 1'b0;

        // Lone loader request while running is granted at once
        bus.l_req  = 1'b1;
        bus.l_addr = 10'd0;
        @(negedge clk);
        chk("lone_l_gnt", 32'(bus.l_gnt), 32'd1);
        tick();
        idle();
        tick();
        tick();

        // Contention: loader forced in once every 9 cycles
        bus.f_req  = 1'b1;
        bus.f_addr = 10'd1;
        bus.l_req  = 1'b1;
        bus.l_addr = 10'd2;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("starve_l_gnt", 32'(bus.l_gnt), 32'((i % 9) == 8));
            chk("starve_f_gnt", 32'(bus.f_gnt), 32'((i % 9) != 8));
            tick();
        end
        idle();
        tick();
        tick();
        tick();

        // Reset one cycle after a fetch grant drops the response
        bus.f_req  = 1'b1;
        bus.f_addr = 10'd1;
        bus.l_req  = 1'b1;
        bus.l_addr = 10'd2;
        @(negedge clk);
        chk("pre_rst_f_gnt", 32'(bus.f_gnt), 32'd1);
        tick();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst_starve", 32'(dut.starve_q), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
            chk("post_rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
            tick();
        end

        // Running loader write below the protect boundary
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = 10'd3;
        bus.l_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("prot_l_gnt", 32'(bus.l_gnt), 32'd1);
        tick();
        idle();
        @(negedge clk);
`ifdef IMEM_ARB_WRITE_PROTECT_EN
        chk("prot_mem_en", 32'(bus.mem_en), 32'd0);
`else
        chk("prot_mem_en", 32'(bus.mem_en), 32'd1);
`endif
        tick();
        @(negedge clk);
        chk("prot_l_rvalid", 32'(bus.l_rvalid), 32'd1);
`ifdef IMEM_ARB_WRITE_PROTECT_EN
        chk("prot_l_err", 32'(bus.l_err), 32'd1);
        chk("prot_ram3", ram[3], 32'h1000_0003);
`else
        chk("prot_l_err", 32'(bus.l_err), 32'd0);
        chk("prot_ram3", ram[3], 32'h0BAD_F00D);
`endif
        tick();

        // Running loader write above the protect boundary
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = 10'd200;
        bus.l_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("hi_l_gnt", 32'(bus.l_gnt), 32'd1);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("hi_l_rvalid", 32'(bus.l_rvalid), 32'd1);
        chk("hi_l_err", 32'(bus.l_err), 32'd0);
        chk("hi_ram200", ram[200], 32'h1234_5678);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous instruction RAM between two requesters: the pipeline fetch stage (read-only) and the program loader/debug port (read/write).
- Lets a program image be loaded or patched without a second memory port.
- Sits between the IF stage and instruction memory.
- Fixed 2-cycle grant-to-data latency, one access per cycle, starvation guard for the loader.

Parameters:
- RAM_SIZE_BIT, 10, word-address width of instruction memory.
- STARVE_LIMIT, 8, consecutive denied loader cycles before the loader is forced a grant (legal range 1..255).
- PROTECT_TOP, 10'd168, first word address loader may write while CPU runs (used only with optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_halt  in  1  CPU halted; loader gets absolute priority
- f_req  in  1  fetch read request
- f_addr  in  RAM_SIZE_BIT  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  32  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  RAM_SIZE_BIT  loader word address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader completion; read data valid on reads
- l_rdata  out  32  loader read data
- l_err  out  1  loader write rejected (optional feature only, else tied 0)
- mem_en  out  1  registered memory enable
- mem_we  out  1  registered memory write enable
- mem_addr  out  RAM_SIZE_BIT  registered memory address
- mem_wdata  out  32  registered memory write data
- mem_rdata  in  32  memory read data, valid one cycle after mem_en

Behaviour:
- Reset values: mem_en, mem_we, mem_addr, mem_wdata, f_rvalid, l_rvalid, l_err = 0. Starve counter = 0. In-flight tags cleared.
- f_gnt/l_gnt are combinational from current req, cpu_halt and starve counter. At most one grant per cycle; no grant without req.
- Requesters hold req/addr/we/wdata stable until their gnt is seen.
- Priority:
  - cpu_halt=1: loader wins.
  - Else, if starve counter == STARVE_LIMIT: loader wins.
  - Else fetch wins.
- Starve counter:
  - +1 when l_req=1 and l_gnt=0; saturates at STARVE_LIMIT.
  - Clears on l_gnt, or when l_req=0.
- Pipeline timing:
  - Cycle N: grant.
  - Edge N→N+1: mem_* register the winner's command; mem_en=0 if no grant.
  - Cycle N+2: owner's rvalid=1 for one cycle; rdata = mem_rdata, passed through combinationally.
- A 2-deep owner tag shift register (none/fetch/loader) routes responses. Back-to-back grants to either side give one rvalid per cycle, in order.
- Loader writes: l_rvalid still pulses at N+2 as an ack, with l_rdata = 0.
- Non-owner rdata is driven 0 when its rvalid is 0.
- Simultaneous requests with cpu_halt toggling take effect the same cycle (combinational).
- Reset mid-operation: in-flight tags are dropped, and no rvalid is emitted for accesses granted before reset.

Optional Feature:
- Macro: IMEM_ARB_WRITE_PROTECT_EN
- Enabled:
  - A loader write with cpu_halt=0 and l_addr < PROTECT_TOP is still granted (handshake completes) but issued with mem_we=0, mem_en=0.
  - l_err pulses with l_rvalid at N+2; no memory change.
  - Writes at/above PROTECT_TOP, and all writes while halted, proceed normally.
- Disabled: no check; l_err tied 0.

Test Plan:
- Reset, no requests: all outputs 0; mem_en stays 0 for 10 cycles.
- f_req held 5 cycles, f_addr 0..4 over RAM preloaded with 0x24170400, 0x24080000, …: f_gnt every cycle; f_rvalid on cycles 2..6 with data in address order.
- cpu_halt=1, l_we=1, l_addr=5, l_wdata=0xDEADBEEF, f_req=1 concurrently: l_gnt=1, f_gnt=0; mem_we=1, addr 5 next cycle. Then l_we=0 read of addr 5: l_rvalid with 0xDEADBEEF.
- cpu_halt=0, f_req and l_req both held continuously (STARVE_LIMIT=8): loader granted exactly once every 9 cycles; fetch granted the other 8.
- Reset asserted one cycle after a fetch grant: no f_rvalid afterwards; counter and mem_* read 0.
- With IMEM_ARB_WRITE_PROTECT_EN, cpu_halt=0, write addr 3 (PROTECT_TOP=168): l_err=1 at N+2 and RAM word 3 unchanged. Write addr 200: l_err=0 and RAM updated.
